// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using double dabble, one input bit per clock, with a start/done handshake.
// Optional leading-zero blanking output is enabled by defining BIN2BCD_SEQ_LZB_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf
`ifdef BIN2BCD_SEQ_LZB_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [BIN_W-1:0]     shreg;
    logic [DIGITS*4-1:0]  work;
    logic [DIGITS*4-1:0]  adj;
    logic [DIGITS*4-1:0]  work_nxt;
    logic                 carry;
    logic                 ovf_work;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 last;

    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Per-digit +3 correction; digits never carry into each other.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = dabble_adj(work[4*i +: 4]);
        end
    end

    assign {carry, work_nxt} = {adj, shreg[BIN_W-1]};

    assign accept = (state == IDLE) && start;
    assign last   = (state == SHIFT) && (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers need no reset: they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg    <= bin;
            work     <= '0;
            cnt      <= '0;
            ovf_work <= 1'b0;
        end else if (state == SHIFT) begin
            shreg    <= shreg << 1;
            work     <= work_nxt;
            cnt      <= cnt + CNT_W'(1);
            ovf_work <= ovf_work | carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            bcd  <= '0;
            ovf  <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                bcd <= work_nxt;
                ovf <= ovf_work | carry;
            end
        end
    end

`ifdef BIN2BCD_SEQ_LZB_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // A digit blanks only when it and every more-significant digit are zero; units never blank.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (work_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank <= '0;
        end else if (last) begin
            blank <= blank_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three parameter sets, handshake timing, reset abort and value sweeps.
// Blank checks are compiled in only when BIN2BCD_SEQ_LZB_EN is defined.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a, ready_a, done_a, ovf_a;
    logic [7:0]  bin_a;
    logic [11:0] bcd_a;
    logic        start_b, ready_b, done_b, ovf_b;
    logic [16:0] bin_b;
    logic [23:0] bcd_b;
    logic        start_c, ready_c, done_c, ovf_c;
    logic [7:0]  bin_c;
    logic [7:0]  bcd_c;
`ifdef BIN2BCD_SEQ_LZB_EN
    logic [2:0]  blank_a;
    logic [5:0]  blank_b;
    logic [1:0]  blank_c;
`endif

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .ready(ready_a),
        .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
`ifdef BIN2BCD_SEQ_LZB_EN
        , .blank(blank_a)
`endif
    );

    bin2bcd_seq #(.BIN_W(17), .DIGITS(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .ready(ready_b),
        .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
`ifdef BIN2BCD_SEQ_LZB_EN
        , .blank(blank_b)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .ready(ready_c),
        .done(done_c), .bcd(bcd_c), .ovf(ovf_c)
`ifdef BIN2BCD_SEQ_LZB_EN
        , .blank(blank_c)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_bcd(input int v, input int nd);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_blank(input int v, input int nd);
        logic [5:0] r;
        int         p;
        r = '0;
        p = 10;
        for (int i = 1; i < nd; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic conv_a(input logic [7:0] v, output int lat);
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = v;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = ~v;
        lat     = 1;
        while (!done_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done_a) chk("timeout_a", 32'd0, 32'd1);
    endtask

    task automatic conv_b(input logic [16:0] v, output int lat);
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = v;
        @(negedge clk);
        start_b = 1'b0;
        bin_b   = '0;
        lat     = 1;
        while (!done_b && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done_b) chk("timeout_b", 32'd0, 32'd1);
    endtask

    task automatic conv_c(input logic [7:0] v, output int lat);
        @(negedge clk);
        start_c = 1'b1;
        bin_c   = v;
        @(negedge clk);
        start_c = 1'b0;
        bin_c   = '0;
        lat     = 1;
        while (!done_c && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done_c) chk("timeout_c", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int k;
        int ndone;

        rst = 1'b1;
        start_a = 1'b0; bin_a = '0;
        start_b = 1'b0; bin_b = '0;
        start_c = 1'b0; bin_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bcd", 32'(bcd_a), 32'h000);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;

        // 255 -> 255 with 9-cycle latency
        conv_a(8'd255, lat);
        chk("t1_lat", 32'(lat), 32'd9);
        chk("t1_bcd", 32'(bcd_a), 32'h255);
        chk("t1_ovf", 32'(ovf_a), 32'd0);
`ifdef BIN2BCD_SEQ_LZB_EN
        chk("t1_blank", 32'(blank_a), 32'b000);
`endif

        conv_a(8'd0, lat);
        chk("t2_bcd0", 32'(bcd_a), 32'h000);
        chk("t2_ovf0", 32'(ovf_a), 32'd0);
`ifdef BIN2BCD_SEQ_LZB_EN
        chk("t2_blank0", 32'(blank_a), 32'b110);
`endif
        conv_a(8'd7, lat);
        chk("t2_bcd7", 32'(bcd_a), 32'h007);
`ifdef BIN2BCD_SEQ_LZB_EN
        chk("t2_blank7", 32'(blank_a), 32'b110);
`endif
        conv_a(8'd70, lat);
        chk("t2_bcd70", 32'(bcd_a), 32'h070);
`ifdef BIN2BCD_SEQ_LZB_EN
        chk("t2_blank70", 32'(blank_a), 32'b100);
`endif

        // start held high: second request taken in the done cycle
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd99;
        @(negedge clk);
        lat = 1;
        while (!done_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t3_lat1", 32'(lat), 32'd9);
        chk("t3_bcd1", 32'(bcd_a), 32'h099);
        bin_a = 8'd100;
        @(negedge clk);
        start_a = 1'b0;
        bin_a   = 8'd3;
        k = 1;
        while (!done_a && k < 40) begin
            if (k == 4) begin
                chk("t3_hold_bcd", 32'(bcd_a), 32'h099);
                chk("t3_busy", 32'(ready_a), 32'd0);
            end
            @(negedge clk);
            k++;
        end
        chk("t3_gap", 32'(k), 32'd9);
        chk("t3_bcd2", 32'(bcd_a), 32'h100);

        // reset during the 4th shift cycle aborts the conversion
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd255;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_ready", 32'(ready_a), 32'd1);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_bcd", 32'(bcd_a), 32'h000);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("t4_no_done", 32'(ndone), 32'd0);

        conv_b(17'd99999, lat);
        chk("t5_lat", 32'(lat), 32'd18);
        chk("t5_bcd_a", 32'(bcd_b), 32'h099999);
        chk("t5_ovf_a", 32'(ovf_b), 32'd0);
        conv_b(17'd131071, lat);
        chk("t5_bcd_b", 32'(bcd_b), 32'h131071);
        chk("t5_ovf_b", 32'(ovf_b), 32'd0);
`ifdef BIN2BCD_SEQ_LZB_EN
        chk("t5_blank", 32'(blank_b), 32'b000000);
`endif

        conv_c(8'd200, lat);
        chk("t6_bcd200", 32'(bcd_c), 32'h00);
        chk("t6_ovf200", 32'(ovf_c), 32'd1);
        conv_c(8'd99, lat);
        chk("t6_bcd99", 32'(bcd_c), 32'h99);
        chk("t6_ovf99", 32'(ovf_c), 32'd0);

        for (int v = 0; v < 256; v++) begin
            conv_a(8'(v), lat);
            chk("sweep_a_bcd", 32'(bcd_a), 32'(ref_bcd(v, 3)));
            chk("sweep_a_ovf", 32'(ovf_a), 32'd0);
`ifdef BIN2BCD_SEQ_LZB_EN
            chk("sweep_a_blank", 32'(blank_a), 32'(ref_blank(v, 3)));
`endif
        end

        for (int v = 0; v < 256; v++) begin
            conv_c(8'(v), lat);
            chk("sweep_c_bcd", 32'(bcd_c), 32'(ref_bcd(v, 2)));
            chk("sweep_c_ovf", 32'(ovf_c), (v >= 100) ? 32'd1 : 32'd0);
`ifdef BIN2BCD_SEQ_LZB_EN
            chk("sweep_c_blank", 32'(blank_c), 32'(ref_blank(v % 100, 2)));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
